// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: run-control state encoding, ms-to-cycle helper
// and the default system clock frequency used by the stopwatch blocks.
package stopwatch_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } sw_state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned freq,
                                               input int unsigned ms);
    return (freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, saturating stability counter and
// one-cycle rising-edge press strobe.
module btn_debounce #(
  parameter int unsigned DB_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = (DB_CYC < 1) ? 1 : $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so returning to the old level restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: debounced start/stop and lap/clear buttons driving
// run enable, clear pulse and lap hold. Optional STOPWATCH_LONGPRESS_CLR_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int unsigned DEBOUNCE_MS  = 10,
  parameter int unsigned LONGPRESS_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss_raw,
  input  logic       btn_lc_raw,
  output logic       run_en,
  output logic       clr_pulse,
  output logic       lap_hold,
  output logic [1:0] state_dbg
);

  localparam int unsigned DB_CYC = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);

  logic ss_p;
  logic lc_p;
  logic lp_p;
  logic lc_level;
  logic ss_lvl_unused;

  btn_debounce #(.DB_CYC(DB_CYC)) u_db_ss (
    .clk       (clk),
    .rst       (rst),
    .btn_raw_i (btn_ss_raw),
    .level_o   (ss_lvl_unused),
    .press_o   (ss_p)
  );

  btn_debounce #(.DB_CYC(DB_CYC)) u_db_lc (
    .clk       (clk),
    .rst       (rst),
    .btn_raw_i (btn_lc_raw),
    .level_o   (lc_level),
    .press_o   (lc_p)
  );

`ifdef STOPWATCH_LONGPRESS_CLR_EN
  localparam int unsigned LP_CYC = ms_to_cycles(CLK_FREQ, LONGPRESS_MS);
  localparam int unsigned HW     = (LP_CYC < 2) ? 1 : $clog2(LP_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LP_CYC);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LP_CYC - 1);

  logic [HW-1:0] hold_cnt_q;
  logic          lp_q;

  // Saturating at LP_CYC makes the fire match happen once per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      lp_q       <= 1'b0;
    end else begin
      lp_q <= lc_level && (hold_cnt_q == HOLD_FIRE);
      if (!lc_level) begin
        hold_cnt_q <= '0;
      end else if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  assign lp_p = lp_q;
`else
  logic lp_unused;
  assign lp_unused = lc_level ^ (LONGPRESS_MS != 0);
  assign lp_p      = 1'b0;
`endif

  sw_state_e state_q;
  logic      run_q;
  logic      clr_q;
  logic      lap_q;

  // Long press overrides everything; otherwise start/stop beats lap/clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      if (lp_p) begin
        state_q <= ST_IDLE;
        run_q   <= 1'b0;
        clr_q   <= 1'b1;
        lap_q   <= 1'b0;
      end else if (ss_p) begin
        unique case (state_q)
          ST_IDLE, ST_STOPPED: begin
            state_q <= ST_RUNNING;
            run_q   <= 1'b1;
            lap_q   <= 1'b0;
          end
          ST_RUNNING: begin
            state_q <= ST_STOPPED;
            run_q   <= 1'b0;
            lap_q   <= 1'b0;
          end
          ST_LAP: begin
            state_q <= ST_STOPPED;
            run_q   <= 1'b0;
            lap_q   <= 1'b1;
          end
        endcase
      end else if (lc_p) begin
        unique case (state_q)
          ST_IDLE: begin
            clr_q <= 1'b1;
          end
          ST_RUNNING: begin
            state_q <= ST_LAP;
            run_q   <= 1'b1;
            lap_q   <= 1'b1;
          end
          ST_LAP: begin
            state_q <= ST_RUNNING;
            run_q   <= 1'b1;
            lap_q   <= 1'b0;
          end
          ST_STOPPED: begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            clr_q   <= 1'b1;
            lap_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign run_en    = run_q;
  assign clr_pulse = clr_q;
  assign lap_hold  = lap_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: window-based debounce model plus state table,
// compared every cycle, with hand-computed edge checks per scenario.
module tb_stopwatch_ctrl;

  localparam int DB = 10;
  localparam int LP = 20;
`ifdef STOPWATCH_LONGPRESS_CLR_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss  = 1'b0;
  logic       lc  = 1'b0;
  logic       run_en;
  logic       clr_pulse;
  logic       lap_hold;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(
    .CLK_FREQ     (10_000),
    .DEBOUNCE_MS  (1),
    .LONGPRESS_MS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_ss_raw (ss),
    .btn_lc_raw (lc),
    .run_en     (run_en),
    .clr_pulse  (clr_pulse),
    .lap_hold   (lap_hold),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Model state: edge counter since reset release, raw sample history,
  // debounced levels, strobes from the previous edge, and expected outputs.
  int cyc = 0;
  bit r_ss [0:1023];
  bit r_lc [0:1023];
  bit db_ss, db_lc, st_ss, st_lc, st_lp;
  int lc_rise;
  int m_state;
  bit m_clr, m_lapflag;
  bit mvalid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // True when the raw samples taken at edges e-2-DB .. e-2 all equal v.
  function automatic bit window_all(input bit sel_lc, input int e, input bit v);
    for (int i = e - 2 - DB; i <= e - 2; i++) begin
      bit s;
      s = (i < 1 || i > 1023) ? 1'b0 : (sel_lc ? r_lc[i] : r_ss[i]);
      if (s != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin : model
    bit nss, nlc, nlp;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0; db_ss = 0; db_lc = 0; st_ss = 0; st_lc = 0; st_lp = 0;
        lc_rise = 0; m_state = 0; m_clr = 0; m_lapflag = 0; mvalid = 1'b1;
        for (int i = 0; i < 1024; i++) begin r_ss[i] = 0; r_lc[i] = 0; end
      end else begin
        cyc++;
        if (cyc <= 1023) begin r_ss[cyc] = ss; r_lc[cyc] = lc; end
        m_clr = 1'b0;
        if (st_lp) begin
          m_state = 0; m_clr = 1; m_lapflag = 0;
        end else if (st_ss) begin
          if (m_state == 3) begin m_state = 2; m_lapflag = 1; end
          else if (m_state == 1) begin m_state = 2; m_lapflag = 0; end
          else m_state = 1;
        end else if (st_lc) begin
          if (m_state == 0) m_clr = 1;
          else if (m_state == 1) m_state = 3;
          else if (m_state == 3) m_state = 1;
          else begin m_state = 0; m_clr = 1; m_lapflag = 0; end
        end
        nlp = LP_EN && db_lc && (cyc - lc_rise == LP);
        nss = 0; nlc = 0;
        if (window_all(1'b0, cyc, !db_ss)) begin db_ss = !db_ss; nss = db_ss; end
        if (window_all(1'b1, cyc, !db_lc)) begin
          db_lc = !db_lc; nlc = db_lc;
          if (db_lc) lc_rise = cyc;
        end
        st_ss = nss; st_lc = nlc; st_lp = nlp;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (mvalid && !rst) begin
        check("state", int'(state_dbg), m_state);
        check("run_en", int'(run_en), int'(m_state == 1 || m_state == 3));
        check("clr_pulse", int'(clr_pulse), int'(m_clr));
        check("lap_hold", int'(lap_hold), int'(m_state == 3 || (m_state == 2 && m_lapflag)));
      end
    end
  end

  task automatic to_edge(input int n);
    int guard;
    guard = 0;
    while (cyc < n) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        errors++;
        $display("FAIL to_edge timeout waiting for edge %0d", n);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ss = 1'b0; lc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stim
    // 1: start press from edge 5 reaches RUNNING at edge 18
    do_reset();
    to_edge(4);  ss = 1;
    to_edge(17); check("t1_state_e17", int'(state_dbg), 0);
    to_edge(18); check("t1_state_e18", int'(state_dbg), 1);
                 check("t1_run_e18", int'(run_en), 1);
    to_edge(25); ss = 0;
    to_edge(40);

    // 2: bounce then steady high, single strobe 12 after last rise (edge 35)
    do_reset();
    for (int i = 0; i < 10; i++) begin
      to_edge(4 + 3 * i);
      ss = (i % 2 == 0);
    end
    to_edge(34); ss = 1;
    to_edge(47); check("t2_state_e47", int'(state_dbg), 0);
    to_edge(48); check("t2_state_e48", int'(state_dbg), 1);
    to_edge(80); check("t2_state_e80", int'(state_dbg), 1);
    ss = 0;
    to_edge(95);

    // 3: RUNNING -> LAP -> STOPPED (held) -> clear to IDLE
    do_reset();
    to_edge(2);   ss = 1;
    to_edge(20);  ss = 0;
    to_edge(40);  lc = 1;
    to_edge(54);  check("t3_state_lap", int'(state_dbg), 3);
                  check("t3_lap_in_lap", int'(lap_hold), 1);
    to_edge(55);  lc = 0;
    to_edge(75);  ss = 1;
    to_edge(89);  check("t3_state_stop", int'(state_dbg), 2);
                  check("t3_lap_in_stop", int'(lap_hold), 1);
                  check("t3_run_stop", int'(run_en), 0);
    to_edge(95);  ss = 0;
    to_edge(100); lc = 1;
    to_edge(113); check("t3_clr_e113", int'(clr_pulse), 0);
    to_edge(114); check("t3_state_idle", int'(state_dbg), 0);
                  check("t3_clr_e114", int'(clr_pulse), 1);
                  check("t3_lap_cleared", int'(lap_hold), 0);
    to_edge(115); check("t3_clr_e115", int'(clr_pulse), 0);
                  lc = 0;
    to_edge(135);

    // 4: both buttons together while IDLE: start wins, no clear
    do_reset();
    to_edge(3);  ss = 1; lc = 1;
    to_edge(16); check("t4_state_e16", int'(state_dbg), 0);
    to_edge(17); check("t4_state_e17", int'(state_dbg), 1);
                 check("t4_clr_e17", int'(clr_pulse), 0);
    to_edge(18); check("t4_clr_e18", int'(clr_pulse), 0);
                 ss = 0; lc = 0;
    to_edge(40);

    // 5: asynchronous reset mid-debounce while RUNNING, button still held
    do_reset();
    to_edge(2);  ss = 1;
    to_edge(20); ss = 0;
    to_edge(40); ss = 1;
    to_edge(45); check("t5_state_pre", int'(state_dbg), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_state", int'(state_dbg), 0);
    check("t5_async_run", int'(run_en), 0);
    check("t5_async_clr", int'(clr_pulse), 0);
    check("t5_async_lap", int'(lap_hold), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    to_edge(13); check("t5_state_e13", int'(state_dbg), 0);
    to_edge(14); check("t5_state_e14", int'(state_dbg), 1);
                 check("t5_run_e14", int'(run_en), 1);
    to_edge(20); ss = 0;
    to_edge(40);

    // 6: lap/clear held 40 cycles while RUNNING
    do_reset();
    to_edge(2);   ss = 1;
    to_edge(20);  ss = 0;
    to_edge(40);  lc = 1;
    to_edge(54);  check("t6_state_lap", int'(state_dbg), 3);
    to_edge(73);  check("t6_state_e73", int'(state_dbg), 3);
`ifdef STOPWATCH_LONGPRESS_CLR_EN
    to_edge(74);  check("t6_lp_state", int'(state_dbg), 0);
                  check("t6_lp_clr", int'(clr_pulse), 1);
                  check("t6_lp_lap", int'(lap_hold), 0);
    to_edge(75);  check("t6_lp_clr_e75", int'(clr_pulse), 0);
    to_edge(80);  lc = 0;
    to_edge(100); check("t6_lp_state_e100", int'(state_dbg), 0);
`else
    to_edge(74);  check("t6_state_e74", int'(state_dbg), 3);
                  check("t6_lap_e74", int'(lap_hold), 1);
    to_edge(80);  lc = 0;
    to_edge(100); check("t6_state_e100", int'(state_dbg), 3);
`endif
    to_edge(110);

    // 7: 10-sample pulse rejected, 11-sample pulse accepted
    do_reset();
    to_edge(2);  ss = 1;
    to_edge(12); ss = 0;
    to_edge(30); check("t7_short_rejected", int'(state_dbg), 0);
                 ss = 1;
    to_edge(41); ss = 0;
    to_edge(43); check("t7_state_e43", int'(state_dbg), 0);
    to_edge(44); check("t7_state_e44", int'(state_dbg), 1);
    to_edge(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
